serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller. Accepts two WIDTH-bit operands and a carry-in
//   over a valid/ready handshake, then drives them LSB-first through a single
//   adder_1bit instance, one bit per clock, with the carry held in a register.
//   Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
//   This is the area-minimal adder option for the arithmetic datapath.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 1..32
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands a, b, cin are valid
//   in_ready   out  1      controller can accept operands (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout are valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result bits, (a+b+cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN
// BEHAVIOUR
//   Clocking: one clock; reset is asynchronous and active-high.
//   Reset: state=IDLE; a_sr, b_sr, sum_sr, carry_q, bit_cnt = 0. Outputs at reset:
//     in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. On in_valid at an edge: a_sr<=a, b_sr<=b, carry_q<=cin,
//     bit_cnt<=0, sum_sr<=0 -> RUN.
//   - RUN: adder inputs = a_sr[0], b_sr[0], carry_q. Each edge: a_sr, b_sr shift right
//     (0 in at MSB); sum_sr<={adder.sum, sum_sr[WIDTH-1:1]}; carry_q<=adder.carry_out;
//     bit_cnt++. When bit_cnt==WIDTH-1 at the edge -> DONE.
//   - DONE: out_valid=1; sum=sum_sr; cout=carry_q. On out_ready -> IDLE.
//     sum/cout hold stable while out_valid=1 and out_ready=0.
//   Latency: operands accepted at edge E; out_valid rises after edge E+WIDTH.
//     Throughput: one add per WIDTH+2 cycles with out_ready tied high.
//   No overlap: in_ready=0 in RUN and DONE; in_valid ignored there.
//   sum/cout driven 0 outside DONE.
//   bit_cnt width = $clog2(WIDTH)+1.
//   WIDTH=1: RUN lasts exactly one cycle.
//   Adder inputs are always driven from reset-cleared registers, never X; the
//     adder's input-legality assertions must never fire.
//   rst asserted in any state (incl. mid-RUN): immediate return to reset values.
//     The partial result is discarded and no out_valid pulse is produced.
//   An out_ready pulse while out_valid=0 has no effect.
// STRUCTURE
//   Package serial_adder_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
//     localparam SA_MAX_WIDTH = 32.
//   Sub-module: one adder_1bit instance (u_fa), reused unchanged. Everything else
//     (FSM, shift registers, counter) stays in this file.
// TESTING
//   1) WIDTH=8, a=0xFF, b=0x01, cin=0 -> out_valid after 8 edges; sum=0x00, cout=1.
//   2) a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
//      Also a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
//   3) Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1,
//      sum/cout stable, in_ready=0. Then out_ready=1 -> IDLE next edge.
//   4) Assert rst after 3 RUN cycles -> same cycle: busy=0, in_ready=1, out_valid=0.
//      A fresh 0x03+0x04 then yields 0x07.
//   5) in_valid and out_ready held high with 3 queued operand pairs -> 3 results,
//      each WIDTH+2 cycles apart, all correct against a+b+cin.
//   6) WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1 one edge after acceptance.
//      Random sweep of 1000 vectors at WIDTH=8 against a reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the supported width ceiling.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder used as the serial datapath core.
// Ports: a, b, carry_in -> sum, carry_out (all 1 bit, combinational).
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

  // Upstream must always present known values.
  always_comb begin
    assert (!$isunknown({a, b, carry_in}))
      else $error("adder_1bit: unknown input");
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands in over valid/ready, LSB-first
// through one full adder, result out over a second valid/ready.
// Ports: clk, rst (async, high); in_valid/in_ready, a, b, cin;
//   out_valid/out_ready, sum, cout; busy (high while adding).
// WIDTH legal range is 1..SA_MAX_WIDTH.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] w_sum_shift;
  logic             r_carry_q;
  logic [CW-1:0]    r_bit_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;

  adder_1bit u_fa (
    .a         (r_a_sr[0]),
    .b         (r_b_sr[0]),
    .carry_in  (r_carry_q),
    .sum       (w_fa_sum),
    .carry_out (w_fa_cout)
  );

  assign w_accept = (r_state == IDLE) && in_valid;

  // New sum bit enters at the MSB; written as shifts so WIDTH=1 works.
  assign w_sum_shift = (r_sum_sr >> 1)
                     | (WIDTH'(w_fa_sum) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (r_bit_cnt == LAST) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    unique case (r_state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        sum       = r_sum_sr;
        cout      = r_carry_q;
      end
      default: ;
    endcase
  end

  // Shift registers, carry and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_sum_sr  <= '0;
      r_carry_q <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_a_sr    <= a;
      r_b_sr    <= b;
      r_sum_sr  <= '0;
      r_carry_q <= cin;
      r_bit_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_sum_sr  <= w_sum_shift;
      r_carry_q <= w_fa_cout;
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end
  end

endmodule
